seq_piso_tx: RTL and testbench
==============================

// Module: seq_piso_tx
// PURPOSE
//  Parallel-in/serial-out transmitter: the sending end of the right-shift serial link.
//  Accepts a WIDTH-bit word over a valid/ready handshake and emits it LSB first,
//  one bit per clock, with a frame-valid qualifier.
//  A right-shift receiver (serial_in -> MSB, shift right) clocking on ser_valid holds
//  the original word after WIDTH bits. Sits between a word-producing datapath and the
//  serial link.
// PARAMETERS
//  WIDTH       8     word width in bits; must be >= 2
//  IDLE_LEVEL  1'b0  level driven on ser_out when no frame is active
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst        in   1      asynchronous, active-high reset
//  flush      in   1      synchronous abort of the current frame
//  in_valid   in   1      in_data is valid
//  in_ready   out  1      transmitter can accept a word this cycle
//  in_data    in   WIDTH  word to transmit
//  ser_out    out  1      serial data, LSB first
//  ser_valid  out  1      ser_out carries a frame bit this cycle
//  ser_last   out  1      current bit is bit WIDTH-1 (last of frame)
//  busy       out  1      frame in progress (== ser_valid)
// BEHAVIOUR
//  Clock and reset:
//  - One clock; reset is asynchronous and active-high.
//  - rst=1: state=IDLE, shreg='0, bit_cnt=0, immediately.
//  - During reset: ser_out=IDLE_LEVEL, ser_valid=0, ser_last=0, busy=0, in_ready=1.
//  - Reset mid-frame drops the frame; no partial word is resumed.
//  FSM states (tx_state_e): IDLE, SHIFT.
//  Accept:
//  - Accept occurs at the edge where in_valid && in_ready && !flush.
//  - On accept: shreg<=in_data, bit_cnt<=0, state<=SHIFT.
//  Latency:
//  - Bit 0 appears on ser_out in the cycle after the accept edge.
//  - Bit i appears i+1 cycles after accept.
//  SHIFT, each edge:
//  - If bit_cnt != WIDTH-1: shreg<=shreg>>1, bit_cnt++.
//  - If bit_cnt == WIDTH-1 and accept: load the new word, giving zero-gap back-to-back frames.
//  - If bit_cnt == WIDTH-1 and no accept: state<=IDLE.
//  Outputs (all from registered state, no in_* -> out combinational path except none):
//  - ser_valid = (state==SHIFT).
//  - ser_out = ser_valid ? shreg[0] : IDLE_LEVEL.
//  - ser_last = ser_valid && bit_cnt==WIDTH-1.
//  - in_ready = (state==IDLE) || ser_last.
//  Flush:
//  - flush=1 at an edge: state<=IDLE, bit_cnt<=0, and no accept.
//  - flush has priority over in_valid, including during the last bit.
//  Handshake:
//  - in_data must be held by the producer only while in_valid && !in_ready.
//  - The transmitter samples in_data only on the accept edge.
//  Counter: bit_cnt width $clog2(WIDTH). It never exceeds WIDTH-1 and wraps only by reload.
//  Throughput: 1 word per WIDTH cycles when in_valid is held high.
// STRUCTURE
//  - seq_pkg: typedef enum logic {IDLE, SHIFT} tx_state_e.
//  - seq_pkg: function cnt_w(int w) returning $clog2(w).
//  - Single module, no sub-modules. The FSM, shift register and bit counter are in one
//    always_ff with nonblocking assignments. Output decode is in always_comb.
// TESTING (WIDTH=8, IDLE_LEVEL=0, paired with a right-shift receiver model)
//  1. Reset: rst=1 mid-SHIFT -> same cycle ser_valid=0, ser_out=0, in_ready=1;
//     after release, no bits until a new accept.
//  2. Single word: in_data=8'hA5 accepted at edge 0 -> ser_out 1,0,1,0,0,1,0,1 on
//     cycles 1..8; ser_last only on cycle 8; receiver holds 8'hA5.
//  3. Back-to-back: in_valid held with 8'h3C then 8'hFF -> 16 contiguous ser_valid
//     cycles; in_ready high only on cycles 0, 8, 16.
//  4. Backpressure: in_valid=1 with 8'h81 while busy at bit 3 -> no accept until ser_last;
//     8'h81 follows with no gap.
//  5. Flush at bit 4 of 8'h0F -> next cycle ser_valid=0, ser_out=0.
//     Flush and in_valid together on ser_last -> no accept, IDLE.
//  6. Random: 1000 random words, random in_valid gaps -> receiver words match the sent
//     order exactly; no ser_valid without a preceding accept.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial transmitter.
// Holds the FSM state encoding and the counter-width helper.
package seq_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } tx_state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/seq_piso_tx.sv
// Parallel-in/serial-out transmitter, LSB first.
// Frames are qualified by ser_valid; ser_last marks the final bit.
module seq_piso_tx
  import seq_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  tx_state_e        state;
  tx_state_e        state_d;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    cnt_d;
  logic             accept;

  // Output decode: everything comes from registered state only.
  always_comb begin
    ser_valid = (state == SHIFT);
    ser_last  = ser_valid && (bit_cnt == LAST);
    ser_out   = ser_valid ? shreg[0] : IDLE_LEVEL;
    busy      = ser_valid;
    in_ready  = !ser_valid || ser_last;
  end

  // Flush wins over a pending word, even on the last bit.
  always_comb begin
    accept = in_valid && in_ready && !flush;
  end

  // Next-state: load, shift, or fall back to idle.
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    cnt_d   = bit_cnt;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = SHIFT;
      shreg_d = in_data;
      cnt_d   = '0;
    end else if (state == SHIFT) begin
      if (bit_cnt != LAST) begin
        shreg_d = shreg >> 1;
        cnt_d   = bit_cnt + 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // FSM, shift register and bit counter share one register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_piso_tx.sv
// Self-checking bench for seq_piso_tx (WIDTH=8, IDLE_LEVEL=0).
// Word-level model plus a right-shift receiver model.
module tb_seq_piso_tx;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic         busy;

  seq_piso_tx #(
    .WIDTH(W),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .ser_out(ser_out),
    .ser_valid(ser_valid),
    .ser_last(ser_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
  endtask

  // Model: which word is on the wire and which bit of it (-1 = idle).
  int           pos = -1;
  logic [W-1:0] mword = '0;
  logic [W-1:0] q[$];
  int           acc_cnt = 0;
  // Receiver model: right-shift register clocked by ser_valid.
  logic [W-1:0] rx = '0;
  int           rx_n = 0;
  int           rx_words = 0;

  always @(negedge clk) begin
    logic       ev, eo, el, er, acc;
    logic [4:0] av, xv;
    logic [W-1:0] ew;
    if (rst) begin
      chk({ser_valid, ser_out, ser_last, in_ready, busy} === 5'b00010,
          "reset_outs", {ser_valid, ser_out, ser_last, in_ready, busy},
          5'b00010);
      pos = -1;
      q.delete();
      rx_n = 0;
    end else begin
      ev = (pos >= 0);
      eo = ev ? mword[pos] : 1'b0;
      el = (pos == W - 1);
      er = !ev || el;
      av = {ser_valid, ser_out, ser_last, in_ready, busy};
      xv = {ev, eo, el, er, ev};
      chk(av === xv, "cycle", av, xv);
      if (ser_valid) begin
        rx = {ser_out, rx[W-1:1]};
        rx_n++;
        if (ser_last) begin
          chk(rx_n == W, "rx_len", rx_n, W);
          if (q.size() == 0) begin
            chk(1'b0, "rx_unexpected", rx, 0);
          end else begin
            ew = q.pop_front();
            chk(rx === ew, "rx_word", rx, ew);
          end
          rx_n = 0;
          rx_words++;
        end
      end else begin
        rx_n = 0;
      end
      acc = in_valid && er && !flush;
      if (flush) begin
        if (pos >= 0 && pos != W - 1 && q.size() > 0) void'(q.pop_back());
        pos = -1;
      end else if (acc) begin
        mword = in_data;
        pos = 0;
        q.push_back(in_data);
        acc_cnt++;
      end else if (pos >= 0) begin
        pos = (pos == W - 1) ? -1 : pos + 1;
      end
    end
  end

  initial begin
    logic [W-1:0] bits;
    logic [W-1:0] lasts;
    logic [17:0]  rdy;
    logic [17:0]  vld;
    logic [15:0]  b16;
    logic         rdy_b3;
    int           base, seen, cyc, rx_base;

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-frame.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk(ser_valid === 1'b0, "rst_async_valid", ser_valid, 0);
    chk(ser_out === 1'b0, "rst_async_out", ser_out, 0);
    chk(in_ready === 1'b1, "rst_async_ready", in_ready, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(ser_valid === 1'b0, "no_bits_after_rst", ser_valid, 0);
    end

    // Single word A5.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    chk(in_ready === 1'b1, "a5_ready_c0", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      bits[i] = ser_out;
      lasts[i] = ser_last;
    end
    chk(bits === 8'hA5, "a5_bits", bits, 8'hA5);
    chk(lasts === 8'h80, "a5_last", lasts, 8'h80);
    repeat (2) @(negedge clk);

    // Back-to-back 3C then FF.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h3C;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      rdy[c] = in_ready;
      vld[c] = ser_valid;
      @(posedge clk); #1;
      if (c == 0) in_data = 8'hFF;
      if (c == 8) in_valid = 1'b0;
    end
    chk(rdy === 18'h30101, "b2b_ready", rdy, 18'h30101);
    chk(vld === 18'h1FFFE, "b2b_valid", vld, 18'h1FFFE);
    repeat (2) @(negedge clk);

    // Backpressure: 81 offered while 55 is at bit 3.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b16[i] = ser_out;
      if (i == 3) rdy_b3 = in_ready;
      @(posedge clk); #1;
      if (i == 2) begin in_valid = 1'b1; in_data = 8'h81; end
      if (i == 7) in_valid = 1'b0;
    end
    chk(rdy_b3 === 1'b0, "bp_ready_bit3", rdy_b3, 0);
    chk(b16 === 16'h8155, "bp_stream", b16, 16'h8155);
    repeat (2) @(negedge clk);

    // Flush at bit 4 of 0F.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h0F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk(ser_valid === 1'b0, "flush_valid", ser_valid, 0);
    chk(ser_out === 1'b0, "flush_out", ser_out, 0);
    repeat (2) @(negedge clk);

    // Flush together with in_valid on the last bit.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h33;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk);
    chk(ser_last === 1'b1, "fl_last_seen", ser_last, 1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk(ser_valid === 1'b0, "fl_last_idle", ser_valid, 0);
    chk(in_ready === 1'b1, "fl_last_ready", in_ready, 1);
    repeat (3) @(negedge clk);

    // Random words with random gaps.
    base = acc_cnt;
    seen = acc_cnt;
    rx_base = rx_words;
    cyc = 0;
    while (acc_cnt - base < 1000 && cyc < 40000) begin
      @(posedge clk); #1;
      cyc++;
      if (!in_valid || acc_cnt != seen) begin
        seen = acc_cnt;
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = W'($urandom);
      end
    end
    in_valid = 1'b0;
    chk(cyc < 40000, "rand_budget", cyc, 40000);
    repeat (20) @(negedge clk);
    chk(q.size() == 0, "rx_drain", q.size(), 0);
    chk(rx_words - rx_base == 1000, "rx_count", rx_words - rx_base, 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
